// File: rtl/deinterleaver_conv.sv
// rtl/deinterleaver_conv.sv - convolutional byte deinterleaver, I branches of (I-1-j)*M delay
//
// Purpose: undoes a convolutional interleaver whose branch j delays by j*M
//          visits. Branch j here delays by (I-1-j)*M visits. All branch FIFOs
//          share one storage array, and each branch owns a contiguous region
//          of that array.
// Optional feature: `define DEINT_SYNC_ALIGN_EN forces a byte that arrives
//          with sync_in=1 onto branch 0. If the commutator was not already at
//          0, the branch pointers, the fill count and primed all restart.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   buf_en     byte strobe, data_in accepted on each edge with buf_en=1
//   data_in    interleaved byte stream
//   sync_in    branch-0 marker (ignored unless DEINT_SYNC_ALIGN_EN)
//   data_out   deinterleaved byte, registered, 1-cycle latency
//   out_valid  one-cycle pulse per accepted byte
//   branch     branch index of the byte on data_out
//   primed     high once every branch delay line holds real data
module deinterleaver_conv #(
    parameter int I = 12,
    parameter int M = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       buf_en,
    input  logic [7:0] data_in,
    input  logic       sync_in,
    output logic [7:0] data_out,
    output logic       out_valid,
    output logic [3:0] branch,
    output logic       primed
);

    localparam int MEM_SIZE = M * I * (I - 1) / 2;
    localparam int AW       = $clog2(MEM_SIZE + 1);
    localparam int MAXD     = (I - 1) * M;
    localparam int PW       = $clog2(MAXD + 1);
    localparam int FILL_MAX = MAXD * I;
    localparam int FW       = $clog2(FILL_MAX + 1);

    logic [7:0]    mem [0:MEM_SIZE-1];
    logic [3:0]    b;
    logic [PW-1:0] ptr [0:I-1];
    logic [FW-1:0] fill;

    logic [3:0]    cur_b;
    logic          realign;
    int            depth_i;
    int            base_i;
    logic [PW-1:0] cur_ptr;
    logic [PW-1:0] ptr_next;
    logic [AW-1:0] addr;
    logic          mem_we;

`ifndef DEINT_SYNC_ALIGN_EN
    logic unused_sync;
    assign unused_sync = sync_in;
`endif

    always_comb begin
        cur_b   = b;
        realign = 1'b0;
`ifdef DEINT_SYNC_ALIGN_EN
        if (buf_en && sync_in) begin
            cur_b   = 4'd0;
            realign = (b != 4'd0);
        end
`endif
        depth_i = (I - 1 - int'(cur_b)) * M;
        // Region base = M * sum_{k<j}(I-1-k). The product j*(2I-1-j) is always even.
        base_i  = M * (int'(cur_b) * (2 * I - 1 - int'(cur_b))) / 2;
        // On a realign, every pointer restarts at 0, and so does this access.
        cur_ptr = realign ? '0 : ptr[cur_b];
        if (depth_i > 0 && int'(cur_ptr) == depth_i - 1) begin
            ptr_next = '0;
        end else begin
            ptr_next = cur_ptr + PW'(1);
        end
        addr   = AW'(base_i + int'(cur_ptr));
        mem_we = buf_en && (depth_i > 0);
    end

    // Storage is never reset. The cell is written after the old value is read
    // into data_out on the same edge, which gives read-then-write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[addr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            b         <= 4'd0;
            fill      <= '0;
            data_out  <= 8'h00;
            branch    <= 4'd0;
            out_valid <= 1'b0;
            primed    <= 1'b0;
            for (int k = 0; k < I; k++) begin
                ptr[k] <= '0;
            end
        end else begin
            out_valid <= buf_en;
            if (buf_en) begin
                branch   <= cur_b;
                data_out <= (depth_i > 0) ? mem[addr] : data_in;
                b        <= (cur_b == 4'(I - 1)) ? 4'd0 : cur_b + 4'd1;
                if (realign) begin
                    for (int k = 0; k < I; k++) begin
                        ptr[k] <= '0;
                    end
                    if (depth_i > 0) begin
                        ptr[cur_b] <= ptr_next;
                    end
                    fill   <= FW'(1);
                    primed <= 1'b0;
                end else begin
                    if (depth_i > 0) begin
                        ptr[cur_b] <= ptr_next;
                    end
                    if (int'(fill) != FILL_MAX) begin
                        fill <= fill + FW'(1);
                        if (int'(fill) + 1 == FILL_MAX) begin
                            primed <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_deinterleaver_conv.sv
// tb/tb_deinterleaver_conv.sv - scoreboard bench for deinterleaver_conv
module tb_deinterleaver_conv;

    localparam int I     = 12;
    localparam int M     = 17;
    localparam int TOTAL = I * (I - 1) * M;  // 2244

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       buf_en = 1'b0;
    logic       sync_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       out_valid;
    logic [3:0] branch;
    logic       primed;

    deinterleaver_conv #(.I(I), .M(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .buf_en    (buf_en),
        .data_in   (data_in),
        .sync_in   (sync_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .branch    (branch),
        .primed    (primed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic [3:0] b;
        bit         chk;
    } exp_t;

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         n = 0;
    int         model_b = 0;
    int         accepted = 0;
    int         vcount = 0;
    bit         prime_ok = 1'b1;
    logic [7:0] last_d = 8'h00;
    logic [3:0] last_b = 4'd0;

    // Reference interleaver: branch j delays by j*M visits, which is j*M*I
    // stream bytes. Its source is 0,1,2,... and its cells start at zero.
    function automatic logic [7:0] ilv(int k);
        int j;
        int s;
        j = k % I;
        s = k - j * M * I;
        return (s >= 0) ? 8'(s) : 8'h00;
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic send(bit en, logic [7:0] d, bit s, bit use_ilv);
        exp_t e;
        int   j;
        buf_en  = en;
        data_in = d;
        sync_in = s;
        if (en) begin
            j = model_b;
`ifdef DEINT_SYNC_ALIGN_EN
            if (s) begin
                if (j != 0) prime_ok = 1'b0;
                j = 0;
            end
`endif
            e.b   = 4'(j);
            e.d   = d;
            e.chk = 1'b0;
            if (j == I - 1) begin
                e.chk = 1'b1;
            end else if (use_ilv && n >= TOTAL) begin
                e.chk = 1'b1;
                e.d   = 8'(n - TOTAL);
            end
            sbq.push_back(e);
            model_b = (j + 1) % I;
        end
        @(posedge clk);
        #1;
        if (en) begin
            n++;
            accepted++;
        end
        if (prime_ok) check("primed", int'(primed), int'(n >= TOTAL));
        buf_en  = 1'b0;
        sync_in = 1'b0;
    endtask

    task automatic do_reset();
        send(1'b0, 8'h00, 1'b0, 1'b0);
        check("queue_drained", sbq.size(), 0);
        #2;
        reset = 1'b0;
        #1;
        check("rst_data_out", int'(data_out), 0);
        check("rst_branch", int'(branch), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_primed", int'(primed), 0);
        #2;
        reset    = 1'b1;
        n        = 0;
        model_b  = 0;
        prime_ok = 1'b1;
    endtask

    // Monitor: compare each output pulse against the scoreboard, and require
    // that the outputs hold on idle cycles.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_d = 8'h00;
                last_b = 4'd0;
            end else if (out_valid) begin
                vcount++;
                if (sbq.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("branch", int'(branch), int'(e.b));
                    if (e.chk) check("data", int'(data_out), int'(e.d));
                end
                last_d = data_out;
                last_b = branch;
            end else begin
                check("hold_data", int'(data_out), int'(last_d));
                check("hold_branch", int'(branch), int'(last_b));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("init_data_out", int'(data_out), 0);
        check("init_branch", int'(branch), 0);
        check("init_out_valid", int'(out_valid), 0);
        check("init_primed", int'(primed), 0);
        reset = 1'b1;

        // Branch 11 passes straight through: A5 at index 11. Then a sync
        // marker arrives at commutator position 5.
        for (int k = 0; k < 12; k++) begin
            send(1'b1, (k == 11) ? 8'hA5 : 8'(k), 1'b0, 1'b0);
        end
        for (int k = 12; k < 17; k++) begin
            send(1'b1, 8'(k), 1'b0, 1'b0);
        end
        send(1'b1, 8'h3C, 1'b1, 1'b0);
        send(1'b1, 8'h44, 1'b0, 1'b0);
        do_reset();

        // Continuous stream through the reference interleaver, past priming.
        for (int k = 0; k < TOTAL + 300; k++) begin
            send(1'b1, ilv(k), 1'b0, 1'b1);
        end

        // Reset in the middle of the stream, between clock edges.
        do_reset();

        // Random gaps of about 50% duty. Idle cycles carry junk data.
        while (n < 5000) begin
            while ($urandom_range(1, 0) == 1) begin
                send(1'b0, 8'($urandom), 1'b0, 1'b1);
            end
            send(1'b1, ilv(n), 1'b0, 1'b1);
        end
        repeat (3) send(1'b0, 8'h00, 1'b0, 1'b0);

        check("final_queue_empty", sbq.size(), 0);
        check("valid_count", vcount, accepted);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/deinterleaver_conv.md
DEINTERLEAVER_CONV -- requirements
Module: deinterleaver_conv

Interface
REQ-001 Parameter I, default 12, number of commutator branches.
REQ-002 Parameter M, default 17, delay-cell unit depth in bytes.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 buf_en  input  1  byte strobe; data_in accepted on each rising edge with buf_en=1.
REQ-006 data_in  input  8  interleaved byte stream.
REQ-007 sync_in  input  1  marks the byte belonging to branch 0; sampled only with buf_en=1.
REQ-008 data_out  output  8  deinterleaved byte, registered.
REQ-009 out_valid  output  1  one-cycle pulse qualifying data_out.
REQ-010 branch  output  4  branch index of the byte currently on data_out.
REQ-011 primed  output  1  high once every branch delay line holds valid data.

Function
REQ-012 Commutator counter b SHALL select the branch for each accepted byte, incrementing 0..I-1 then wrapping to 0; it holds when buf_en=0.
REQ-013 Branch j SHALL be a FIFO delay of D(j)=(I-1-j)*M branch visits (branch 0: 187, branch 11: 0 with defaults), complementing the interleaver's j*M delay.
REQ-014 Storage SHALL be one shared array of M*I*(I-1)/2 bytes (1122 by default) addressed by per-branch base offset plus per-branch pointer.
REQ-015 On an accepted byte for branch j with D(j)>0, the oldest byte at pointer p(j) SHALL be read and data_in written to the same location in the same cycle; p(j) then increments, wrapping from D(j)-1 to 0.
REQ-016 Branch I-1 (D=0) SHALL pass data_in directly to the output register.
REQ-017 data_out, branch and out_valid SHALL update on the edge after acceptance: latency exactly 1 clock; out_valid=1 for exactly one cycle per accepted byte.
REQ-018 With buf_en=0, data_out and branch SHALL hold; out_valid=0; no pointer or counter changes.
REQ-019 End-to-end interleaver+deinterleaver delay SHALL be I*(I-1)*M accepted bytes (2244 by default) for every branch.
REQ-020 A fill counter SHALL count accepted bytes, saturating at (I-1)*M*I; primed SHALL rise on the edge on which the counter saturates and stay high until reset.
REQ-021 Before primed, data_out for branches not yet filled is the uninitialised array content; benches SHALL not check it.
REQ-022 Back-to-back buf_en=1 every cycle SHALL be sustained with no stall.

Reset
REQ-023 While reset=0: b=0, all p(j)=0, fill counter=0, data_out=8'h00, branch=0, out_valid=0, primed=0; asserts immediately, independent of clk.
REQ-024 Storage array SHALL NOT be reset; reset mid-stream restarts at branch 0 and requires a fresh fill (primed=0).
REQ-025 Deassertion SHALL take effect on the first rising edge after reset returns high.

Configuration
REQ-026 Macro DEINT_SYNC_ALIGN_EN: when defined, an accepted byte with sync_in=1 SHALL be forced to branch 0 (b treated as 0, next byte branch 1); if b was not already 0, all p(j), fill counter and primed SHALL clear in that cycle (realignment).
REQ-027 Without DEINT_SYNC_ALIGN_EN, sync_in port remains present but SHALL be ignored; the commutator free-runs from reset.

Verification
REQ-028 Reset then buf_en=1 continuously with bytes 0,1,2,... (mod 256) through a reference interleaver -> after primed, data_out equals the original sequence delayed 2244 bytes, branch cycles 0..11.
REQ-029 Accepted byte index 11 (branch 11), data_in=8'hA5 -> next cycle data_out=8'hA5, branch=11, out_valid=1.
REQ-030 Random buf_en gaps (~50% duty) over 5000 bytes -> identical output sequence to REQ-028, out_valid count equals accepted count, no output change on idle cycles.
REQ-031 Exactly 2243 accepted bytes -> primed=0; the 2244th -> primed=1 on that edge.
REQ-032 reset pulsed low mid-stream between clock edges -> outputs zero immediately, primed=0, next accepted byte goes to branch 0.
REQ-033 With DEINT_SYNC_ALIGN_EN, sync_in=1 on a byte when b=5 -> byte routed to branch 0, primed clears, following byte branch 1; without the macro same stimulus -> byte routed to branch 5.
